// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: light codes, lane indices and the
// per-lane sensor state machine encoding.
package tl_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;
    localparam logic [1:0] LIGHT_OFF    = 2'b11;

    localparam int LANE_NN = 0;
    localparam int LANE_NS = 1;
    localparam int LANE_TH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PENDING,
        ST_SERVED,
        ST_HOLDOFF
    } lane_state_e;

endpackage

// File: rtl/sensor_lane.sv
// One approach: synchronizer, debounce/latch/holdoff FSM and stuck-sensor
// detector. Green on the lane's own light is the acknowledge for its demand.
module sensor_lane
    import tl_pkg::*;
#(
    parameter int DEB_CYC   = 500,
    parameter int HOLD_CYC  = 20000,
    parameter int STUCK_CYC = 600000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_raw_i,
    input  logic [1:0] light_i,
    output logic       request_o,
    output logic       req_next_o,
    output logic       fault_o
);

    localparam int CNT_W = $clog2(STUCK_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic              s1_q, s2_q;
    lane_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  stk_q, stk_d;
    logic              fault_q, fault_d;
    logic              req_q, req_d;
    logic              green;
    logic              s;

    assign s     = s2_q;
    assign green = (light_i == LIGHT_GREEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stk_q   <= '0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            s1_q    <= sensor_raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stk_q   <= stk_d;
            fault_q <= fault_d;
            req_q   <= req_d;
        end
    end

    // Green is checked before the sensor, the sensor before the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (s && !green) begin
                    state_d = ST_ARM;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_ARM: begin
                if (green || !s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PENDING;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PENDING: begin
                if (green) state_d = ST_SERVED;
            end
            ST_SERVED: begin
                if (!green) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A stuck lane is demanded continuously except while it is actually green.
    always_comb begin
        if (!s)                      stk_d = '0;
        else if (stk_q == STUCK_MAX) stk_d = stk_q;
        else                         stk_d = stk_q + CNT_ONE;
        fault_d = fault_q | (stk_d == STUCK_MAX);
        req_d   = fault_d ? (state_d != ST_SERVED) : (state_d == ST_PENDING);
    end

    assign request_o  = req_q;
    assign req_next_o = req_d;
    assign fault_o    = fault_q;

endmodule

// File: rtl/sensor_request.sv
// Vehicle-detector front end: one sensor_lane per approach plus a registered
// count of lanes currently demanding service.
module sensor_request
    import tl_pkg::*;
#(
    parameter int N_LANES   = 3,
    parameter int DEB_CYC   = 500,
    parameter int HOLD_CYC  = 20000,
    parameter int STUCK_CYC = 600000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_LANES-1:0]   sensor_raw,
    input  logic [2*N_LANES-1:0] light,
    output logic [N_LANES-1:0]   request,
    output logic [N_LANES-1:0]   fault,
    output logic [1:0]           pending_cnt
);

    logic [N_LANES-1:0] req_next;
    logic [1:0]         pending_cnt_q, pending_cnt_d;

    function automatic logic [1:0] sat_popcount(input logic [N_LANES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < N_LANES; i++) begin
            if (v[i]) n++;
        end
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        sensor_lane #(
            .DEB_CYC   (DEB_CYC),
            .HOLD_CYC  (HOLD_CYC),
            .STUCK_CYC (STUCK_CYC)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .sensor_raw_i (sensor_raw[g]),
            .light_i      (light[2*g+1 -: 2]),
            .request_o    (request[g]),
            .req_next_o   (req_next[g]),
            .fault_o      (fault[g])
        );
    end

    // Counting the next-state vector keeps the count aligned with request.
    assign pending_cnt_d = sat_popcount(req_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_cnt_q <= 2'd0;
        else        pending_cnt_q <= pending_cnt_d;
    end

    assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_sensor_request.sv
// Directed bench for sensor_request with short debounce/holdoff/stuck timings.
module tb_sensor_request;
    import tl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sensor_raw;
    logic [5:0] light;
    logic [2:0] request;
    logic [2:0] fault;
    logic [1:0] pending_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sensor_request #(
        .N_LANES   (3),
        .DEB_CYC   (4),
        .HOLD_CYC  (8),
        .STUCK_CYC (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sensor_raw  (sensor_raw),
        .light       (light),
        .request     (request),
        .fault       (fault),
        .pending_cnt (pending_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        sensor_raw = 3'b000;
        light      = 6'b000000;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        sensor_raw = 3'b000;
        light      = 6'b000000;
        tick(2);
        check("reset_request", 32'(request), 32'd0);
        check("reset_fault",   32'(fault),   32'd0);
        check("reset_pending", 32'(pending_cnt), 32'd0);
        rst_n = 1'b1;

        // Debounce pass on lane 0
        apply_reset();
        sensor_raw[0] = 1'b1;
        tick(5);
        check("deb_before_rise", 32'(request[0]), 32'd0);
        tick(1);
        check("deb_rise",        32'(request[0]), 32'd1);
        check("deb_pending_cnt", 32'(pending_cnt), 32'd1);
        tick(4);
        sensor_raw[0] = 1'b0;
        tick(3);
        check("deb_latched",     32'(request[0]), 32'd1);
        check("deb_pending_hold", 32'(pending_cnt), 32'd1);

        // Glitch reject on lane 2, then clean re-arm from IDLE
        apply_reset();
        sensor_raw[2] = 1'b1;
        tick(3);
        sensor_raw[2] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("glitch_no_request", 32'(request[2]), 32'd0);
        end
        sensor_raw[2] = 1'b1;
        tick(5);
        check("glitch_rearm_before", 32'(request[2]), 32'd0);
        tick(1);
        check("glitch_rearm_rise",   32'(request[2]), 32'd1);

        // Service and holdoff on lane 1, sensor held throughout
        apply_reset();
        sensor_raw[1] = 1'b1;
        tick(6);
        check("svc_pending", 32'(request[1]), 32'd1);
        light[3:2] = LIGHT_GREEN;
        tick(1);
        check("svc_fall",        32'(request[1]), 32'd0);
        check("svc_pending_cnt", 32'(pending_cnt), 32'd0);
        tick(4);
        light[3:2] = LIGHT_YELLOW;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("svc_holdoff_low", 32'(request[1]), 32'd0);
        end
        tick(1);
        check("svc_rerise",        32'(request[1]), 32'd1);
        check("svc_rerise_cnt",    32'(pending_cnt), 32'd1);

        // Green arrives while lane 2 is arming
        apply_reset();
        sensor_raw[2] = 1'b1;
        tick(4);
        light[5:4] = LIGHT_GREEN;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("arm_green_no_req", 32'(request[2]), 32'd0);
        end
        light[5:4] = LIGHT_RED;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("arm_rearm_low", 32'(request[2]), 32'd0);
        end
        tick(1);
        check("arm_rearm_rise", 32'(request[2]), 32'd1);

        // Stuck sensor on lane 0
        apply_reset();
        sensor_raw[0] = 1'b1;
        tick(6);
        check("stuck_pending", 32'(request[0]), 32'd1);
        tick(27);
        check("stuck_before_fault", 32'(fault), 32'd0);
        tick(1);
        check("stuck_fault",        32'(fault), 32'd1);
        check("stuck_req",          32'(request[0]), 32'd1);
        light[1:0] = LIGHT_GREEN;
        tick(1);
        check("stuck_green_req",    32'(request[0]), 32'd0);
        check("stuck_green_cnt",    32'(pending_cnt), 32'd0);
        light[1:0] = LIGHT_RED;
        tick(1);
        check("stuck_holdoff_req",  32'(request[0]), 32'd1);
        check("stuck_holdoff_cnt",  32'(pending_cnt), 32'd1);
        tick(4);
        sensor_raw[0] = 1'b0;
        tick(10);
        check("stuck_fault_sticky", 32'(fault), 32'd1);
        check("stuck_req_sticky",   32'(request[0]), 32'd1);

        // Async reset with every lane demanding and lane 0 faulted
        sensor_raw = 3'b111;
        tick(6);
        check("all_pending_req", 32'(request), 32'd7);
        check("all_pending_cnt", 32'(pending_cnt), 32'd3);
        check("all_fault",       32'(fault), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_req",   32'(request), 32'd0);
        check("async_fault", 32'(fault), 32'd0);
        check("async_cnt",   32'(pending_cnt), 32'd0);
        #4;
        rst_n = 1'b1;
        tick(1);
        check("post_reset_req", 32'(request), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
